// File: rtl/mandelbrot_dispatcher.sv
// Raster-order pixel/coordinate generator feeding one mandelbrot_iterator.
// Optional DISPATCH_PERF_EN adds frame_cycles/stall_cycles counters.
module mandelbrot_dispatcher #(
   parameter int H_PIX = 640,
   parameter int V_PIX = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [26:0] x_min,
   input  logic [26:0] y_max,
   input  logic [26:0] step,
   input  logic        ready,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [26:0] X,
   output logic [26:0] Y,
   output logic        valid,
   output logic        last,
   output logic        busy,
   output logic        done
`ifdef DISPATCH_PERF_EN
   ,
   output logic [31:0] frame_cycles,
   output logic [31:0] stall_cycles
`endif
);

   localparam logic [9:0] XL = 10'(H_PIX - 1);
   localparam logic [9:0] YL = 10'(V_PIX - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [26:0] xr, yr, sr;
   logic        latch, init, adv, fin;
   logic [9:0]  nx, ny;

   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      init    = 1'b0;
      adv     = 1'b0;
      fin     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               latch   = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            init    = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            if (valid && ready) begin
               if (last) begin
                  fin     = 1'b1;
                  state_d = DONE;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Coordinates of the pixel that follows the one being presented
   always_comb begin
      nx = pix_x + 10'd1;
      ny = pix_y;
      if (pix_x == XL) begin
         nx = 10'd0;
         ny = pix_y + 10'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xr    <= '0;
         yr    <= '0;
         sr    <= '0;
         pix_x <= '0;
         pix_y <= '0;
         X     <= '0;
         Y     <= '0;
         valid <= 1'b0;
         last  <= 1'b0;
      end else begin
         if (latch) begin
            xr <= x_min;
            yr <= y_max;
            sr <= step;
         end
         if (init) begin
            pix_x <= '0;
            pix_y <= '0;
            X     <= xr;
            Y     <= yr;
            valid <= 1'b1;
            last  <= (XL == 10'd0) && (YL == 10'd0);
         end
         if (fin) valid <= 1'b0;
         if (adv) begin
            pix_x <= nx;
            pix_y <= ny;
            last  <= (nx == XL) && (ny == YL);
            if (pix_x == XL) begin
               X <= xr;
               Y <= Y - sr;
            end else begin
               X <= X + sr;
            end
         end
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

`ifdef DISPATCH_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cycles <= '0;
         stall_cycles <= '0;
      end else if (latch) begin
         frame_cycles <= '0;
         stall_cycles <= '0;
      end else begin
         if (busy && frame_cycles != '1)
            frame_cycles <= frame_cycles + 32'd1;
         if (state_q == RUN && !ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mandelbrot_dispatcher.sv
// Bench for mandelbrot_dispatcher: table of frames checked via a pixel
// scoreboard, plus parameter-isolation, ignored-start and mid-frame reset.
module tb_mandelbrot_dispatcher;

   localparam int H = 4;
   localparam int V = 3;
   localparam int N = H * V;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [26:0] x_min, y_max, step;
   logic        ready;
   logic [9:0]  pix_x, pix_y;
   logic [26:0] X, Y;
   logic        valid, last, busy, done;
`ifdef DISPATCH_PERF_EN
   logic [31:0] frame_cycles, stall_cycles;
`endif

   mandelbrot_dispatcher #(.H_PIX(H), .V_PIX(V)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .x_min(x_min),
      .y_max(y_max),
      .step(step),
      .ready(ready),
      .pix_x(pix_x),
      .pix_y(pix_y),
      .X(X),
      .Y(Y),
      .valid(valid),
      .last(last),
      .busy(busy),
      .done(done)
`ifdef DISPATCH_PERF_EN
      ,
      .frame_cycles(frame_cycles),
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [26:0] xm;
      logic [26:0] ym;
      logic [26:0] st;
      int          mode;
      logic [26:0] ex30;
      logic [26:0] ey2;
   } vec_t;

   typedef struct {
      logic [9:0]  px;
      logic [9:0]  py;
      logic [26:0] x;
      logic [26:0] y;
      logic        lst;
   } pix_t;

   pix_t q[$];
   int   tests = 0;
   int   fails = 0;
   vec_t vecs[4];

   task automatic chk(input string name, input logic [79:0] act,
                      input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_frame(input logic [26:0] xm, input logic [26:0] ym,
                            input logic [26:0] st, input int mode,
                            input bit chg, input bit spur,
                            input logic [26:0] ex30,
                            input logic [26:0] ey2);
      int   cyc, runc, stalls, ph;
      bit   exp_done, fin, rdy;
      pix_t e;
      cyc = 0; runc = 0; stalls = 0; ph = 0;
      exp_done = 0; fin = 0;
      @(negedge clk);
      x_min = xm; y_max = ym; step = st;
      start = 1'b1; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 80'(busy), 80'(1));
      chk("valid_in_load", 80'(valid), 80'(0));
      if (chg) begin
         x_min = 27'h1234567; y_max = 27'h2222222; step = 27'h0000100;
      end
      q.delete();
      for (int m = 0; m < V; m++)
         for (int n = 0; n < H; n++) begin
            e.px  = 10'(n);
            e.py  = 10'(m);
            e.x   = 27'(xm + 27'(n) * st);
            e.y   = 27'(ym - 27'(m) * st);
            e.lst = (n == H - 1) && (m == V - 1);
            q.push_back(e);
         end
      while (!fin && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         chk("done", 80'(done), 80'(exp_done));
         if (ph == 0 && exp_done) begin
            chk("valid_drop", 80'(valid), 80'(0));
            chk("busy_in_done", 80'(busy), 80'(1));
            if (spur) start = 1'b1;
            exp_done = 0;
            ph = 2;
         end else if (ph == 0) begin
            chk("valid_run", 80'(valid), 80'(1));
            rdy = 1'b1;
            if (mode == 1) rdy = (cyc % 2 == 0);
            if (mode == 2) rdy = 1'($urandom_range(0, 1));
            ready = rdy;
            if (spur && cyc == 3) start = 1'b1;
            if (valid) begin
               runc++;
               if (q.size() == 0) begin
                  chk("extra_pixel", 80'(1), 80'(0));
               end else begin
                  e = q[0];
                  chk("pixel", {5'd0, pix_x, pix_y, X, Y, last},
                      {5'd0, e.px, e.py, e.x, e.y, e.lst});
                  if (rdy) begin
                     void'(q.pop_front());
                     if (e.px == 10'd3 && e.py == 10'd0)
                        chk("x_at_col3", 80'(X), 80'(ex30));
                     if (e.px == 10'd0 && e.py == 10'd2)
                        chk("row2", {26'd0, X, Y}, {26'd0, xm, ey2});
                     if (e.lst) exp_done = 1;
                  end else begin
                     stalls++;
                  end
               end
            end
         end else if (ph == 2) begin
            chk("busy_fall", 80'(busy), 80'(0));
            ph = 3;
         end else begin
            chk("no_restart", {78'd0, busy, valid}, 80'(0));
            fin = 1;
         end
      end
      chk("frame_timeout", 80'(fin), 80'(1));
      chk("queue_empty", 80'(q.size()), 80'(0));
      chk("run_cycles", 80'(runc), 80'(N + stalls));
      if (mode == 1) chk("run_cycles_bp", 80'(runc), 80'(24));
`ifdef DISPATCH_PERF_EN
      chk("frame_cycles", 80'(frame_cycles), 80'(runc + 2));
      chk("stall_cycles", 80'(stall_cycles), 80'(stalls));
`endif
   endtask

   initial begin
      bit found;
      vecs[0] = '{27'h7000000, 27'h0800000, 27'h0400000, 0,
                  27'h7C00000, 27'h0000000};
      vecs[1] = '{27'h7000000, 27'h0800000, 27'h0400000, 1,
                  27'h7C00000, 27'h0000000};
      vecs[2] = '{27'h3FFFFFF, 27'h4000000, 27'h0000001, 2,
                  27'h4000002, 27'h3FFFFFE};
      vecs[3] = '{27'h0000000, 27'h0000000, 27'h7FFFFFF, 0,
                  27'h7FFFFFD, 27'h0000002};

      reset = 1'b1; start = 1'b0; ready = 1'b0;
      x_min = '0; y_max = '0; step = '0;
      #2;
      chk("reset_state", {5'd0, pix_x, pix_y, X, Y},  80'(0));
      chk("reset_flags", {76'd0, valid, last, busy, done}, 80'(0));
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 4; i++)
         run_frame(vecs[i].xm, vecs[i].ym, vecs[i].st, vecs[i].mode,
                   1'b0, 1'b0, vecs[i].ex30, vecs[i].ey2);

      run_frame(vecs[0].xm, vecs[0].ym, vecs[0].st, 2, 1'b1, 1'b0,
                vecs[0].ex30, vecs[0].ey2);
      run_frame(vecs[3].xm, vecs[3].ym, vecs[3].st, 0, 1'b0, 1'b1,
                vecs[3].ex30, vecs[3].ey2);

      @(negedge clk);
      x_min = vecs[0].xm; y_max = vecs[0].ym; step = vecs[0].st;
      start = 1'b1; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge clk);
         if (valid && pix_x == 10'd2 && pix_y == 10'd1) found = 1;
      end
      chk("reach_2_1", 80'(found), 80'(1));
      #2 reset = 1'b1;
      #1;
      chk("async_reset", {5'd0, pix_x, pix_y, X, Y}, 80'(0));
      chk("async_reset_flags", {76'd0, valid, last, busy, done}, 80'(0));
      @(negedge clk);
      chk("no_done_in_reset", 80'(done), 80'(0));
      reset = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", {78'd0, busy, done}, 80'(0));
      run_frame(vecs[0].xm, vecs[0].ym, vecs[0].st, 0, 1'b0, 1'b0,
                vecs[0].ex30, vecs[0].ey2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
